irq_pend_ctrl: RTL and testbench
================================

// Module: irq_pend_ctrl
// PURPOSE
//  Request-capture and dispatch stage upstream of the 4-bit priority encoder (pri_enc).
//  Synchronises raw request lines, latches rising edges as sticky pending bits, applies a mask,
//  and drives the masked vector into pri_enc.a. Takes pri_enc.y back as enc_idx, freezes it,
//  presents it to a consumer under a valid/ack handshake, and clears the serviced pending bit.
// PARAMETERS
//  N      4   number of request lines (pri_enc width)
//  IDX_W  2   index width, = $clog2(N)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  irq_in     in   N      raw asynchronous request levels
//  mask_we    in   1      load mask register this cycle
//  mask_wdata in   N      new mask, 1 = bit blocked
//  pend_out   out  N      pending & ~mask, to pri_enc.a (registered terms, combinational AND)
//  enc_idx    in   IDX_W  pri_enc.y, index of highest set bit of pend_out
//  irq_valid  out  1      dispatched index valid
//  irq_idx    out  IDX_W  frozen index, stable while irq_valid=1
//  irq_ack    in   1      consumer accepts irq_idx; sampled only when irq_valid=1
//  overrun    out  N      sticky: a new edge arrived on an already-pending bit
//  ovr_clr    in   1      clears all overrun bits
// BEHAVIOUR
//  - Reset (rst_n=0, any time, including mid-handshake): sync flops, pending, mask=0, overrun=0,
//    irq_idx=0, irq_valid=0, FSM=IDLE. pend_out=0 follows combinationally.
//  - Sync: each irq_in bit goes through 2 flops, then a third delay flop for edge detection.
//    A rise of irq_in is seen as an edge on the 3rd rising clk. pending[i] is set at that same edge.
//    Levels held high do not re-trigger; only 0->1 transitions do.
//  - Edge on bit i while pending[i]=1: pending stays 1, overrun[i] is set.
//    ovr_clr and a new overrun event in the same cycle: set wins.
//  - Mask: mask_we loads at the next edge. Masked bits still latch pending and overrun,
//    and reappear in pend_out when unmasked.
//  - FSM states and transitions:
//    IDLE : if pend_out != 0, latch irq_idx <= enc_idx and go to REQ.
//    REQ  : irq_valid=1, irq_idx held. On irq_ack=1, clear pending[irq_idx] and go to IDLE.
//  - Cycle timing:
//    REQ is entered 1 cycle after pend_out goes nonzero.
//    irq_valid drops the cycle after ack.
//    Back-to-back dispatch: minimum 1 IDLE cycle between grants, since IDLE re-samples enc_idx.
//  - No pre-emption: a higher-priority arrival during REQ does not change irq_idx.
//  - Mask written during REQ: irq_idx is unaffected and the ack still clears the latched bit.
//  - Same-cycle clear (ack) and new edge on the same bit: set wins.
//    pending stays 1 and overrun is not set.
//  - enc_idx is trusted only when pend_out != 0. X/Z on enc_idx in IDLE with pend_out=0 is ignored.
// STRUCTURE
//  - Package irq_pkg: N, IDX_W, typedef enum {IDLE, REQ} irq_state_t.
//  - One sub-module, irq_edge_sync: per-bit 2-flop synchroniser plus delay flop,
//    output a 1-cycle rise pulse. Instantiated N wide.
//  - The top level holds the pending, mask and overrun registers and the FSM.
//    pri_enc is instantiated by the parent, not inside this block.
// TESTING (bench instantiates irq_pend_ctrl + pri_enc back-to-back)
//  1. Single request: reset, irq_in=4'b0010
//     -> pend_out=0010 on 3rd clk, irq_valid=1 one clk later with irq_idx=01;
//        ack -> pend_out=0000, irq_valid=0.
//  2. Priority and no pre-emption: irq_in=4'b0011
//     -> irq_idx=01. In REQ raise bit 3 -> irq_idx stays 01.
//        After ack, next grant irq_idx=11, then 00.
//  3. Mask: mask=4'b1000, irq_in=4'b1001
//     -> grant irq_idx=00 only. After ack, pend_out=0000.
//        Write mask=0 -> pend_out=1000 and irq_idx=11 granted.
//  4. Overrun: pulse bit 2 twice without ack -> overrun=0100, single grant irq_idx=10.
//     ovr_clr -> overrun=0000.
//  5. Simultaneous events: ack of bit 1 in the same cycle as a new bit-1 edge
//     -> pending[1] stays 1, overrun[1]=0, re-grant irq_idx=01.
//  6. Reset mid-operation: assert rst_n=0 while irq_valid=1
//     -> irq_valid, pend_out, overrun all 0 immediately.
//        Held-high irq_in does not re-trigger after release.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and index helper for the interrupt
// pending/dispatch stage that feeds the external priority encoder.
package irq_pkg;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_t;

  function automatic logic [N-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] one_v;
    one_v = {{(N-1){1'b0}}, 1'b1};
    return one_v << idx;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One request line: two-flop synchroniser plus a delay flop, producing a
// single-cycle pulse on each synchronised 0->1 transition.
module irq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic dly_r;

  // Reset high so a level already asserted at reset release is not taken as a new edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      dly_r  <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
      dly_r  <= sync_r;
    end
  end

  assign rise = sync_r & ~dly_r;

endmodule

// File: rtl/irq_pend_ctrl.sv
// Captures request edges as sticky pending bits, masks them towards the
// priority encoder, and dispatches the encoded index over a valid/ack handshake.
module irq_pend_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     irq_in,
  input  logic             mask_we,
  input  logic [N-1:0]     mask_wdata,
  output logic [N-1:0]     pend_out,
  input  logic [IDX_W-1:0] enc_idx,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  input  logic             irq_ack,
  output logic [N-1:0]     overrun,
  input  logic             ovr_clr
);

  logic [N-1:0]     rise_s;
  logic [N-1:0]     pending_r;
  logic [N-1:0]     mask_r;
  logic [N-1:0]     overrun_r;
  logic [N-1:0]     clr_s;
  logic [N-1:0]     pending_nxt_s;
  logic [N-1:0]     ovr_set_s;
  logic [N-1:0]     overrun_nxt_s;
  irq_state_t       state_r;
  irq_state_t       state_nxt_s;
  logic [IDX_W-1:0] irq_idx_r;
  logic [IDX_W-1:0] idx_nxt_s;
  logic             irq_valid_r;
  logic             valid_nxt_s;

  for (genvar i = 0; i < N; i++) begin : g_sync
    irq_edge_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (irq_in[i]),
      .rise  (rise_s[i])
    );
  end

  assign pend_out  = pending_r & ~mask_r;
  assign irq_valid = irq_valid_r;
  assign irq_idx   = irq_idx_r;
  assign overrun   = overrun_r;

  // FSM state and dispatched-index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      irq_idx_r   <= {IDX_W{1'b0}};
      irq_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      irq_idx_r   <= idx_nxt_s;
      irq_valid_r <= valid_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pend_out != {N{1'b0}}) state_nxt_s = REQ;
        else                       state_nxt_s = IDLE;
      end
      REQ: begin
        if (irq_ack) state_nxt_s = IDLE;
        else         state_nxt_s = REQ;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: index capture, serviced-bit clear, next valid
  always_comb begin
    idx_nxt_s = irq_idx_r;
    clr_s     = {N{1'b0}};
    case (state_r)
      IDLE: begin
        // enc_idx is only meaningful while something is pending
        if (pend_out != {N{1'b0}}) idx_nxt_s = enc_idx;
        else                       idx_nxt_s = irq_idx_r;
      end
      REQ: begin
        if (irq_ack) clr_s = idx_onehot(irq_idx_r);
        else         clr_s = {N{1'b0}};
      end
      default: begin
        idx_nxt_s = irq_idx_r;
        clr_s     = {N{1'b0}};
      end
    endcase
    valid_nxt_s = (state_nxt_s == REQ);
  end

  // A new edge beats a same-cycle clear, and beats ovr_clr for overrun
  always_comb begin
    ovr_set_s     = rise_s & pending_r & ~clr_s;
    pending_nxt_s = (pending_r & ~clr_s) | rise_s;
    if (ovr_clr) overrun_nxt_s = ovr_set_s;
    else         overrun_nxt_s = overrun_r | ovr_set_s;
  end

  // Pending, mask and overrun registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {N{1'b0}};
      mask_r    <= {N{1'b0}};
      overrun_r <= {N{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
      overrun_r <= overrun_nxt_s;
      if (mask_we) mask_r <= mask_wdata;
    end
  end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Directed bench for irq_pend_ctrl with a behavioural 4-bit priority encoder
// closing the pend_out -> enc_idx loop.
module tb_irq_pend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] pend_out;
  logic [1:0] enc_idx;
  logic       irq_valid;
  logic [1:0] irq_idx;
  logic       irq_ack;
  logic [3:0] overrun;
  logic       ovr_clr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] irq;
    logic       mwe;
    logic [3:0] mw;
    logic       ack;
    logic [3:0] pend;
    logic       valid;
    logic [1:0] idx;
  } vec_t;

  vec_t vecs[$];

  irq_pend_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pend_out   (pend_out),
    .enc_idx    (enc_idx),
    .irq_valid  (irq_valid),
    .irq_idx    (irq_idx),
    .irq_ack    (irq_ack),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  // priority encoder: index of highest set bit
  always_comb begin
    enc_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (pend_out[i]) enc_idx = 2'(i);
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] irq_v, input logic ack_v, input logic clr_v);
    irq_in  = irq_v;
    irq_ack = ack_v;
    ovr_clr = clr_v;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] irq, input logic mwe, input logic [3:0] mw,
                              input logic ack, input logic [3:0] pend, input logic valid,
                              input logic [1:0] idx);
    vec_t v;
    v.irq = irq; v.mwe = mwe; v.mw = mw; v.ack = ack;
    v.pend = pend; v.valid = valid; v.idx = idx;
    return v;
  endfunction

  initial begin
    // flush synchronisers after reset
    for (int k = 0; k < 3; k++) vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0));
    // single request
    vecs.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0));
    vecs.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1));
    vecs.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1));
    // priority, no pre-emption
    vecs.push_back(mk(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1));
    vecs.push_back(mk(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1));
    vecs.push_back(mk(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b0, 2'd1));
    vecs.push_back(mk(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 2'd1));
    vecs.push_back(mk(4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 2'd1));
    vecs.push_back(mk(4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0011, 1'b1, 2'd1));
    vecs.push_back(mk(4'b1011, 1'b0, 4'b0000, 1'b0, 4'b1011, 1'b1, 2'd1));
    vecs.push_back(mk(4'b1011, 1'b0, 4'b0000, 1'b1, 4'b1001, 1'b0, 2'd1));
    vecs.push_back(mk(4'b1011, 1'b0, 4'b0000, 1'b0, 4'b1001, 1'b1, 2'd3));
    vecs.push_back(mk(4'b1011, 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd3));
    vecs.push_back(mk(4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0));
    vecs.push_back(mk(4'b1011, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0));
    // mask
    vecs.push_back(mk(4'b1001, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk(4'b1001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk(4'b1001, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0));
    vecs.push_back(mk(4'b1001, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0));
    vecs.push_back(mk(4'b1001, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk(4'b1001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk(4'b1001, 1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd0));
    vecs.push_back(mk(4'b1001, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3));
    vecs.push_back(mk(4'b1001, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3));

    rst_n = 1'b0; irq_in = 4'b0000; mask_we = 1'b0; mask_wdata = 4'b0000;
    irq_ack = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pend_out", pend_out, 4'b0000);
    chk("reset irq_valid", {3'b000, irq_valid}, 4'b0000);
    chk("reset irq_idx", {2'b00, irq_idx}, 4'b0000);
    chk("reset overrun", overrun, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      mask_we    = vecs[i].mwe;
      mask_wdata = vecs[i].mw;
      cyc(vecs[i].irq, vecs[i].ack, 1'b0);
      chk($sformatf("vec%0d pend_out", i), pend_out, vecs[i].pend);
      chk($sformatf("vec%0d irq_valid", i), {3'b000, irq_valid}, {3'b000, vecs[i].valid});
      chk($sformatf("vec%0d irq_idx", i), {2'b00, irq_idx}, {2'b00, vecs[i].idx});
      chk($sformatf("vec%0d overrun", i), overrun, 4'b0000);
    end
    mask_we = 1'b0; mask_wdata = 4'b0000;

    // overrun: two pulses on bit 2 before any ack
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("ovr first pend", pend_out, 4'b0100);
    cyc(4'b0100, 1'b0, 1'b0);
    chk("ovr grant valid", {3'b000, irq_valid}, 4'b0001);
    chk("ovr grant idx", {2'b00, irq_idx}, 4'b0010);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("ovr set", overrun, 4'b0100);
    chk("ovr pend held", pend_out, 4'b0100);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("ovr ack pend", pend_out, 4'b0000);
    chk("ovr ack valid", {3'b000, irq_valid}, 4'b0000);
    chk("ovr sticky", overrun, 4'b0100);
    repeat (3) cyc(4'b0000, 1'b0, 1'b0);
    chk("ovr single grant", {3'b000, irq_valid}, 4'b0000);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("ovr cleared", overrun, 4'b0000);

    // ack and new edge on bit 1 in the same cycle
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("sim grant idx", {2'b00, irq_idx}, 4'b0001);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("sim valid before ack", {3'b000, irq_valid}, 4'b0001);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("sim pend kept", pend_out, 4'b0010);
    chk("sim no overrun", overrun, 4'b0000);
    chk("sim valid dropped", {3'b000, irq_valid}, 4'b0000);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("sim regrant valid", {3'b000, irq_valid}, 4'b0001);
    chk("sim regrant idx", {2'b00, irq_idx}, 4'b0001);
    cyc(4'b0000, 1'b1, 1'b0);
    chk("sim final pend", pend_out, 4'b0000);

    // reset mid-handshake with overrun set and bit 0 held high
    repeat (3) cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    repeat (3) cyc(4'b0001, 1'b0, 1'b0);
    chk("rst pre valid", {3'b000, irq_valid}, 4'b0001);
    chk("rst pre overrun", overrun, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("rst async valid", {3'b000, irq_valid}, 4'b0000);
    chk("rst async pend", pend_out, 4'b0000);
    chk("rst async overrun", overrun, 4'b0000);
    chk("rst async idx", {2'b00, irq_idx}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0001, 1'b0, 1'b0);
      chk($sformatf("held %0d pend", k), pend_out, 4'b0000);
      chk($sformatf("held %0d valid", k), {3'b000, irq_valid}, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
